mat_row_seq: RTL and testbench

MAT_ROW_SEQ -- requirements
Module: mat_row_seq

---
 rtl/mat_row_seq.sv | 139 +++++++++++++
 tb/tb_mat_row_seq.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_row_seq.sv
// mat_row_seq: walks a 5x5 int8 matrix row by row through an external
// row-by-scalar multiplier and reassembles the returned rows.
module mat_row_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [199:0] mat_a,
  input  logic [7:0]   scalar,
  output logic [39:0]  req_row,
  output logic [7:0]   req_n,
  output logic         req_valid,
  input  logic [39:0]  rsp_row,
  input  logic         rsp_ovf,
  input  logic         rsp_valid,
  output logic [199:0] mat_out,
  output logic         ovf,
  output logic         err,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [4:0][39:0] a_q, a_d;
  logic [7:0]      n_q, n_d;
  logic [4:0][39:0] out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [39:0]     req_row_q, req_row_d;
  logic [7:0]      req_n_q, req_n_d;
  logic [2:0]      slot;

  // Row 0 lives in the top 40 bits, so packed slot index is 4 - row.
  assign slot = 3'd4 - row_q;

  // Next-state, operand latching and result assembly.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wcnt_d    = wcnt_q;
    a_d       = a_q;
    n_d       = n_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    req_row_d = req_row_q;
    req_n_d   = req_n_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = mat_a;
          n_d     = scalar;
          out_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          row_d   = 3'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_row_d = a_q[slot];
        req_n_d   = n_q;
        wcnt_d    = 4'd0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          out_d[slot] = rsp_row;
          ovf_d       = ovf_q | rsp_ovf;
          if (row_q == 3'd4) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (wcnt_q == 4'd15) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      wcnt_q    <= '0;
      a_q       <= '0;
      n_q       <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      req_row_q <= '0;
      req_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      wcnt_q    <= wcnt_d;
      a_q       <= a_d;
      n_q       <= n_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      req_row_q <= req_row_d;
      req_n_q   <= req_n_d;
    end
  end

  // Request bus shows the live row in ISSUE, otherwise the last one sent.
  always_comb begin
    req_valid = (state_q == S_ISSUE);
    req_row   = req_valid ? a_q[slot] : req_row_q;
    req_n     = req_valid ? n_q : req_n_q;
    busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done      = (state_q == S_DONE);
    mat_out   = out_q;
    ovf       = ovf_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_mat_row_seq.sv
// tb_mat_row_seq: directed bench for mat_row_seq with a
// latency-programmable row multiplier model.
module tb_mat_row_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [199:0] mat_a;
  logic [7:0]   scalar;
  logic [39:0]  req_row;
  logic [7:0]   req_n;
  logic         req_valid;
  logic [39:0]  rsp_row;
  logic         rsp_ovf;
  logic         rsp_valid;
  logic [199:0] mat_out;
  logic         ovf;
  logic         err;
  logic         busy;
  logic         done;

  logic [39:0] mdl_row, inj_row;
  logic        mdl_valid, inj_valid;
  logic        mdl_ovf, inj_ovf;

  int resp_lat;
  int silent_row;
  int ovf_row;
  int pulses;
  int checks;
  int fails;

  assign rsp_valid = mdl_valid | inj_valid;
  assign rsp_ovf   = mdl_ovf | inj_ovf;
  assign rsp_row   = inj_valid ? inj_row : mdl_row;

  mat_row_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_a     (mat_a),
    .scalar    (scalar),
    .req_row   (req_row),
    .req_n     (req_n),
    .req_valid (req_valid),
    .rsp_row   (rsp_row),
    .rsp_ovf   (rsp_ovf),
    .rsp_valid (rsp_valid),
    .mat_out   (mat_out),
    .ovf       (ovf),
    .err       (err),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] mul_row(
    input logic [39:0] r,
    input logic [7:0]  n
  );
    logic [39:0] o;
    logic signed [15:0] p;
    o = '0;
    for (int i = 0; i < 5; i++) begin
      p = $signed(r[8*i +: 8]) * $signed(n);
      o[8*i +: 8] = p[7:0];
    end
    return o;
  endfunction

  // Multiplier model: answers each request resp_lat cycles later.
  always begin : responder
    logic [39:0] r;
    logic [7:0]  n;
    int          idx;
    int          my_idx;
    @(negedge clk);
    mdl_valid = 1'b0;
    mdl_ovf   = 1'b0;
    if (busy !== 1'b1) idx = 0;
    if (req_valid === 1'b1) begin
      r      = req_row;
      n      = req_n;
      my_idx = idx;
      idx    = idx + 1;
      pulses = pulses + 1;
      repeat (resp_lat) @(negedge clk);
      if (my_idx != silent_row) begin
        mdl_row   = mul_row(r, n);
        mdl_ovf   = (my_idx == ovf_row);
        mdl_valid = 1'b1;
      end
    end
  end

  task automatic start_op(
    input logic [199:0] a,
    input logic [7:0]   s
  );
    @(negedge clk);
    mat_a  = a;
    scalar = s;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n  = i + 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  localparam logic [199:0] A_BASIC = {5{40'h0203040500}};
  localparam logic [199:0] R_BASIC = {5{40'h06090C0F00}};

  task automatic test_reset;
    bit saw_busy;
    saw_busy = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = ~start;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    start = 1'b0;
    #1;
    checks++;
    if (saw_busy !== 1'b0) begin
      $display("FAIL reset_busy got=%0b want=0", saw_busy);
      fails++;
    end
    checks++;
    if ({mat_out, req_row, req_n, req_valid, ovf, err, busy, done}
        !== '0) begin
      $display("FAIL reset_outs got mat_out=%h req_row=%h req_n=%h",
               mat_out, req_row, req_n);
      fails++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    bit ok;
    int p0;
    resp_lat   = 2;
    silent_row = -1;
    ovf_row    = -1;
    p0 = pulses;
    start_op(A_BASIC, 8'd3);
    wait_done(n, ok);
    checks++;
    if (!ok || n != 16) begin
      $display("FAIL basic_latency got=%0d ok=%0b want=16", n, ok);
      fails++;
    end
    checks++;
    if (pulses - p0 != 5) begin
      $display("FAIL basic_pulses got=%0d want=5", pulses - p0);
      fails++;
    end
    checks++;
    if (mat_out !== R_BASIC) begin
      $display("FAIL basic_mat got=%h want=%h", mat_out, R_BASIC);
      fails++;
    end
    checks++;
    if ({ovf, err, busy} !== 3'b000) begin
      $display("FAIL basic_flags got=%b want=000", {ovf, err, busy});
      fails++;
    end
    checks++;
    if ({req_row, req_n} !== {40'h0203040500, 8'h03}) begin
      $display("FAIL basic_req_hold got=%h/%h want=0203040500/03",
               req_row, req_n);
      fails++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ovf;
    int  n;
    bit  ok;
    int  seen;
    logic ovf_a, ovf_b;
    resp_lat   = 2;
    silent_row = -1;
    ovf_row    = 2;
    seen  = 0;
    ovf_a = 1'bx;
    ovf_b = 1'bx;
    ok    = 1'b0;
    start_op({5{40'h0A0B0C0D00}}, 8'd11);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
        seen++;
        if (seen == 3) ovf_a = ovf;
        if (seen == 4) ovf_b = ovf;
      end
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ovf_a !== 1'b0 || ovf_b !== 1'b1) begin
      $display("FAIL ovf_step got=%b%b want=01", ovf_a, ovf_b);
      fails++;
    end
    checks++;
    if (!ok || ovf !== 1'b1 || err !== 1'b0) begin
      $display("FAIL ovf_done got ok=%0b ovf=%b err=%b want 1/1/0",
               ok, ovf, err);
      fails++;
    end
    checks++;
    if (mat_out !== {5{40'h6E79848F00}}) begin
      $display("FAIL ovf_mat got=%h want=%h",
               mat_out, {5{40'h6E79848F00}});
      fails++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      $display("FAIL ovf_hold got=%b want=1", ovf);
      fails++;
    end
    ovf_row = -1;
    start_op(A_BASIC, 8'd3);
    @(negedge clk);
    checks++;
    if ({ovf, busy} !== 2'b01) begin
      $display("FAIL ovf_clear got=%b want=01", {ovf, busy});
      fails++;
    end
    wait_done(n, ok);
    checks++;
    if (!ok || ovf !== 1'b0 || mat_out !== R_BASIC) begin
      $display("FAIL ovf_rerun got ok=%0b ovf=%b mat=%h",
               ok, ovf, mat_out);
      fails++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    bit ok;
    resp_lat   = 2;
    silent_row = 1;
    ovf_row    = -1;
    start_op(A_BASIC, 8'd3);
    wait_done(n, ok);
    checks++;
    if (!ok || n != 21) begin
      $display("FAIL timeout_latency got=%0d ok=%0b want=21", n, ok);
      fails++;
    end
    checks++;
    if ({err, ovf} !== 2'b10) begin
      $display("FAIL timeout_flags got=%b want=10", {err, ovf});
      fails++;
    end
    checks++;
    if (mat_out !== {40'h06090C0F00, 160'h0}) begin
      $display("FAIL timeout_mat got=%h want=%h",
               mat_out, {40'h06090C0F00, 160'h0});
      fails++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL timeout_hold got=%b want=1", err);
      fails++;
    end
    silent_row = -1;
  endtask

  task automatic test_reset_mid;
    int n;
    bit ok;
    int p0;
    resp_lat   = 4;
    silent_row = -1;
    ovf_row    = -1;
    p0 = pulses;
    start_op(A_BASIC, 8'd3);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pulses - p0 >= 4) break;
    end
    @(negedge clk);
    checks++;
    if ({busy, req_valid} !== 2'b10) begin
      $display("FAIL rstmid_pre got=%b want=10", {busy, req_valid});
      fails++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mat_out, req_row, req_n, req_valid, ovf, err, busy, done}
        !== '0) begin
      $display("FAIL rstmid_outs got mat=%h req=%h/%h busy=%b",
               mat_out, req_row, req_n, busy);
      fails++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    resp_lat = 2;
    start_op({5{40'h02FD04FB00}}, 8'hFD);
    wait_done(n, ok);
    checks++;
    if (!ok || n != 16) begin
      $display("FAIL rstmid_latency got=%0d ok=%0b want=16", n, ok);
      fails++;
    end
    checks++;
    if (mat_out !== {5{40'hFA09F40F00}} || {ovf, err} !== 2'b00) begin
      $display("FAIL rstmid_mat got=%h want=%h",
               mat_out, {5{40'hFA09F40F00}});
      fails++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore;
    int n;
    bit ok;
    resp_lat   = 3;
    silent_row = -1;
    ovf_row    = -1;
    start_op(A_BASIC, 8'd3);
    @(negedge clk);
    @(negedge clk);
    mat_a  = {5{40'h7F7F7F7F7F}};
    scalar = 8'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, ok);
    checks++;
    if (!ok || n + 3 != 21) begin
      $display("FAIL ignore_latency got=%0d ok=%0b want=21", n + 3, ok);
      fails++;
    end
    checks++;
    if (mat_out !== R_BASIC) begin
      $display("FAIL ignore_mat got=%h want=%h", mat_out, R_BASIC);
      fails++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, req_valid} !== 3'b000) begin
      $display("FAIL ignore_done_start got=%b want=000",
               {busy, done, req_valid});
      fails++;
    end
    inj_row   = 40'hDEADBEEF12;
    inj_ovf   = 1'b1;
    inj_valid = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    inj_ovf   = 1'b0;
    @(negedge clk);
    checks++;
    if (mat_out !== R_BASIC || {ovf, err, busy} !== 3'b000) begin
      $display("FAIL ignore_idle_rsp got mat=%h flags=%b",
               mat_out, {ovf, err, busy});
      fails++;
    end
    mat_a = A_BASIC;
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    pulses     = 0;
    resp_lat   = 2;
    silent_row = -1;
    ovf_row    = -1;
    rst        = 1'b0;
    start      = 1'b0;
    mat_a      = '0;
    scalar     = '0;
    mdl_row    = '0;
    mdl_valid  = 1'b0;
    mdl_ovf    = 1'b0;
    inj_row    = '0;
    inj_valid  = 1'b0;
    inj_ovf    = 1'b0;
    test_reset();
    test_basic();
    test_ovf();
    test_timeout();
    test_reset_mid();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
